// File: rtl/cache_instruction_sequencer_pkg.sv
// Shared definitions for the cache<->regfile transfer front end.
//   - Default field widths (slot, address, register, beat count)
//   - regfile_instruction: one beat presented to the load/store pipeline
//   - seq_state_e: sequencer FSM encoding
//   - beat_conflict(): RAW hazard test between a candidate beat and one
//     history entry
package cache_instruction_sequencer_pkg;

  localparam int CIS_SLOT_W = 2;
  localparam int CIS_ADDR_W = 11;
  localparam int CIS_REG_W  = 2;
  localparam int CIS_CNT_W  = 4;

  typedef struct packed {
    logic                  valid;
    logic                  is_load;
    logic [CIS_SLOT_W-1:0] slot;
    logic [CIS_ADDR_W-1:0] addr;
    logic [CIS_REG_W-1:0]  reg_idx;
  } regfile_instruction;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_ZERO  = 2'd2
  } seq_state_e;

  // A load must wait for an in-flight store to the same cache location; a
  // store must wait for an in-flight load into the register it reads.
  // Beats travelling in the same direction never depend on each other.
  function automatic logic beat_conflict(input regfile_instruction cand,
                                         input regfile_instruction hist);
    logic hit;
    hit = 1'b0;
    if (cand.valid && hist.valid) begin
      if (cand.is_load && !hist.is_load) begin
        hit = (cand.slot == hist.slot) && (cand.addr == hist.addr);
      end else if (!cand.is_load && hist.is_load) begin
        hit = (cand.reg_idx == hist.reg_idx);
      end else begin
        hit = 1'b0;
      end
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cache_hazard_tracker.sv
// Two-deep history of the beats handed to the load/store pipeline, covering
// its 2-cycle write latency, plus the combinational stall decision for the
// next candidate beat.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous, active-high; clears the history
//   shift_in in   beat entering the pipeline this cycle (valid=0 on bubbles)
//   cand     in   beat the sequencer would like to issue next
//   stall    out  1 = cand conflicts with a beat still in flight
module cache_hazard_tracker
  import cache_instruction_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  regfile_instruction shift_in,
  input  regfile_instruction cand,
  output logic               stall
);

  regfile_instruction hist0_r;
  regfile_instruction hist1_r;

  // History shift: shifts every cycle, bubbles enter as valid=0 entries.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist0_r <= '0;
      hist1_r <= '0;
    end else begin
      hist1_r <= hist0_r;
      hist0_r <= shift_in;
    end
  end

  // Stall decision against both in-flight beats.
  always_comb begin
    stall = beat_conflict(cand, hist0_r) || beat_conflict(cand, hist1_r);
  end

endmodule

// File: rtl/cache_instruction_sequencer.sv
// Front end of the cache<->regfile transfer pipeline. Accepts one macro
// command and expands it into one regfile_instruction beat per cycle,
// inserting bubbles while a beat depends on one still in flight.
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_is_load    1 = cache->regfile, 0 = regfile->cache
//   cmd_slot       cache slot, fixed for the whole command
//   cmd_addr       address of the first beat (wraps inside the slot)
//   cmd_stride     address increment per beat
//   cmd_reg        register of the first beat (wraps)
//   cmd_count      number of beats, 0 allowed
//   instr          registered beat to the pipeline, qualified by instr.valid
//   busy           FSM not idle
//   done           registered 1-cycle completion pulse
module cache_instruction_sequencer
  import cache_instruction_sequencer_pkg::*;
#(
  parameter int SLOT_W = CIS_SLOT_W,
  parameter int ADDR_W = CIS_ADDR_W,
  parameter int REG_W  = CIS_REG_W,
  parameter int CNT_W  = CIS_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_load,
  input  logic [SLOT_W-1:0]  cmd_slot,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [ADDR_W-1:0]  cmd_stride,
  input  logic [REG_W-1:0]   cmd_reg,
  input  logic [CNT_W-1:0]   cmd_count,
  output regfile_instruction instr,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] REG_ONE  = {{(REG_W-1){1'b0}}, 1'b1};

  seq_state_e         state_r;
  seq_state_e         state_nxt_s;
  logic               is_load_r;
  logic [SLOT_W-1:0]  slot_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W-1:0]  stride_r;
  logic [REG_W-1:0]   reg_r;
  logic [CNT_W-1:0]   remain_r;
  regfile_instruction instr_r;
  regfile_instruction instr_nxt_s;
  regfile_instruction cand_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               stall_s;
  logic               accept_s;
  logic               emit_s;

  // Handshake: ready only while idle and out of reset.
  always_comb begin
    cmd_ready = (state_r == SEQ_IDLE) && !reset;
    accept_s  = cmd_valid && cmd_ready;
  end

  // Candidate beat from the current pointers; exists only while beats remain.
  always_comb begin
    cand_s.valid   = (state_r == SEQ_ISSUE) && (remain_r != CNT_ZERO);
    cand_s.is_load = is_load_r;
    cand_s.slot    = slot_r;
    cand_s.addr    = addr_r;
    cand_s.reg_idx = reg_r;
  end

  cache_hazard_tracker u_hazard (
    .clk      (clk),
    .reset    (reset),
    .shift_in (instr_nxt_s),
    .cand     (cand_s),
    .stall    (stall_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state. ISSUE lingers one cycle after the last beat so that done
  // coincides with that beat and the FSM is idle in the following cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      SEQ_IDLE: begin
        if (accept_s) begin
          if (cmd_count == CNT_ZERO) begin
            state_nxt_s = SEQ_ZERO;
          end else begin
            state_nxt_s = SEQ_ISSUE;
          end
        end else begin
          state_nxt_s = SEQ_IDLE;
        end
      end
      SEQ_ISSUE: begin
        if (remain_r == CNT_ZERO) begin
          state_nxt_s = SEQ_IDLE;
        end else begin
          state_nxt_s = SEQ_ISSUE;
        end
      end
      SEQ_ZERO: state_nxt_s = SEQ_IDLE;
      default:  state_nxt_s = SEQ_IDLE;
    endcase
  end

  // FSM outputs: next beat (bubbles are all-zero) and next done pulse.
  always_comb begin
    emit_s = cand_s.valid && !stall_s;
    if (emit_s) begin
      instr_nxt_s = cand_s;
    end else begin
      instr_nxt_s = '0;
    end
    if (accept_s && (cmd_count == CNT_ZERO)) begin
      done_nxt_s = 1'b1;
    end else if (emit_s && (remain_r == CNT_ONE)) begin
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
    end
  end

  // Command pointers: captured at acceptance, stepped once per emitted beat.
  // Address arithmetic stays ADDR_W wide so it never carries into the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_load_r <= 1'b0;
      slot_r    <= {SLOT_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      stride_r  <= {ADDR_W{1'b0}};
      reg_r     <= {REG_W{1'b0}};
      remain_r  <= CNT_ZERO;
    end else if (accept_s) begin
      is_load_r <= cmd_is_load;
      slot_r    <= cmd_slot;
      addr_r    <= cmd_addr;
      stride_r  <= cmd_stride;
      reg_r     <= cmd_reg;
      remain_r  <= cmd_count;
    end else if (emit_s) begin
      addr_r    <= addr_r + stride_r;
      reg_r     <= reg_r + REG_ONE;
      remain_r  <= remain_r - CNT_ONE;
    end else begin
      remain_r  <= remain_r;
    end
  end

  // Registered pipeline beat and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r <= '0;
      done_r  <= 1'b0;
    end else begin
      instr_r <= instr_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign instr = instr_r;
  assign done  = done_r;
  assign busy  = (state_r != SEQ_IDLE);

endmodule

// File: tb/tb_cache_instruction_sequencer.sv
// Scoreboard bench: the issuing task pushes expected beats/done pulses with
// their cycle numbers; a negedge monitor pops and compares whatever the DUT
// presents. The hazard tracker is also exercised directly for stall cases.
module tb_cache_instruction_sequencer;
  import cache_instruction_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready, cmd_is_load;
  logic [1:0] cmd_slot, cmd_reg;
  logic [10:0] cmd_addr, cmd_stride;
  logic [3:0] cmd_count;
  regfile_instruction instr;
  logic busy, done;

  logic trk_reset;
  regfile_instruction trk_in, trk_cand;
  logic trk_stall;

  cache_instruction_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_load(cmd_is_load), .cmd_slot(cmd_slot), .cmd_addr(cmd_addr),
    .cmd_stride(cmd_stride), .cmd_reg(cmd_reg), .cmd_count(cmd_count),
    .instr(instr), .busy(busy), .done(done)
  );

  cache_hazard_tracker u_trk (
    .clk(clk), .reset(trk_reset), .shift_in(trk_in), .cand(trk_cand), .stall(trk_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          cyc;
    logic        is_load;
    logic [1:0]  slot;
    logic [10:0] addr;
    logic [1:0]  rg;
  } beat_t;

  beat_t exp_q[$];
  int    done_q[$];
  beat_t mh0, mh1;
  bit    mh0_v = 1'b0, mh1_v = 1'b0;
  beat_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_conflict(input beat_t c, input beat_t h);
    if (c.is_load && !h.is_load) return (c.slot == h.slot) && (c.addr == h.addr);
    if (!c.is_load && h.is_load) return c.rg == h.rg;
    return 1'b0;
  endfunction

  // Monitor: every presented beat / done pulse must match the next expectation.
  always @(negedge clk) begin
    if (instr.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got addr %0h at cycle %0d, want no beat", instr.addr, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat{cyc,ld,slot,addr,reg}",
              {cyc, instr.is_load, instr.slot, instr.addr, instr.reg_idx},
              {mon_e.cyc, mon_e.is_load, mon_e.slot, mon_e.addr, mon_e.rg});
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Offer a command, wait for acceptance, then predict its beats and done.
  task automatic issue(input bit ld, input logic [1:0] slot, input logic [10:0] addr,
                       input logic [10:0] stride, input logic [1:0] rg,
                       input logic [3:0] cnt, output int acc);
    int c;
    int waited;
    beat_t b;
    logic [10:0] cur_addr;
    logic [1:0] cur_reg;
    acc = -1;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_is_load = ld; cmd_slot = slot; cmd_addr = addr;
    cmd_stride = stride; cmd_reg = rg; cmd_count = cnt;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    if (cmd_ready !== 1'b1) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    // scramble inputs after acceptance; they must be ignored
    cmd_valid = 1'b0; cmd_is_load = ~ld; cmd_slot = ~slot; cmd_addr = ~addr;
    cmd_stride = ~stride; cmd_reg = ~rg; cmd_count = 4'd9;
    c = acc + 1;
    cur_addr = addr;
    cur_reg = rg;
    for (int i = 0; i < cnt; i++) begin
      b.is_load = ld; b.slot = slot; b.addr = cur_addr; b.rg = cur_reg;
      while ((mh0_v && mh0.cyc >= c - 2 && model_conflict(b, mh0)) ||
             (mh1_v && mh1.cyc >= c - 2 && model_conflict(b, mh1))) c++;
      b.cyc = c;
      exp_q.push_back(b);
      mh1 = mh0; mh1_v = mh0_v; mh0 = b; mh0_v = 1'b1;
      cur_addr = cur_addr + stride;
      cur_reg = cur_reg + 2'd1;
      c++;
    end
    if (cnt == 4'd0) done_q.push_back(acc);
    else done_q.push_back(c - 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_pending", exp_q.size() + done_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; trk_reset = 1'b1;
    cmd_valid = 1'b0; cmd_is_load = 1'b0; cmd_slot = 2'd0; cmd_addr = 11'd0;
    cmd_stride = 11'd0; cmd_reg = 2'd0; cmd_count = 4'd0;
    trk_in = '0; trk_cand = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_instr", instr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    // 1: load, three beats, ready returns one cycle after the last beat
    issue(1'b1, 2'd1, 11'h010, 11'd4, 2'd0, 4'd3, n);
    wait_cyc(n + 3);
    check("t1_ready_last_beat", cmd_ready, 0);
    check("t1_busy_last_beat", busy, 1);
    wait_cyc(n + 4);
    check("t1_ready_after", cmd_ready, 1);
    check("t1_busy_after", busy, 0);
    drain();

    // 2: store with address wrap inside slot 2 and register wrap
    issue(1'b0, 2'd2, 11'h7FE, 11'd3, 2'd3, 4'd2, n);
    drain();

    // 3: store then load to the same location
    issue(1'b0, 2'd0, 11'h020, 11'd1, 2'd0, 4'd1, n);
    issue(1'b1, 2'd0, 11'h020, 11'd1, 2'd1, 4'd1, n);
    drain();

    // 4: load into reg1, then stores from reg1 and reg2
    issue(1'b1, 2'd0, 11'h100, 11'd1, 2'd1, 4'd1, n);
    issue(1'b0, 2'd0, 11'h200, 11'd1, 2'd1, 4'd1, n);
    issue(1'b0, 2'd0, 11'h201, 11'd1, 2'd2, 4'd1, n);
    drain();

    // 5: zero-beat command
    issue(1'b0, 2'd1, 11'h055, 11'd1, 2'd0, 4'd0, n);
    check("t5_busy", busy, 1);
    check("t5_done", done, 1);
    check("t5_ready", cmd_ready, 0);
    wait_cyc(n + 1);
    check("t5_busy_after", busy, 0);
    check("t5_done_after", done, 0);
    check("t5_ready_after", cmd_ready, 1);
    drain();

    // 6: reset during the second beat of a five-beat command
    issue(1'b1, 2'd3, 11'h300, 11'd2, 2'd0, 4'd5, n);
    wait_cyc(n + 2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_valid_in_reset", instr.valid, 0);
    check("t6_done_in_reset", done, 0);
    check("t6_busy_in_reset", busy, 0);
    exp_q.delete();
    done_q.delete();
    mh0_v = 1'b0; mh1_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 2'd2, 11'h040, 11'd5, 2'd1, 4'd2, n);
    drain();

    // 7: hazard tracker stall cases
    @(negedge clk);
    trk_reset = 1'b0;
    trk_in = '{valid:1'b1, is_load:1'b0, slot:2'd0, addr:11'h020, reg_idx:2'd0};
    @(negedge clk);
    trk_in = '0;
    trk_cand = '{valid:1'b1, is_load:1'b1, slot:2'd0, addr:11'h020, reg_idx:2'd3};
    #1 check("trk_load_after_store_h0", trk_stall, 1);
    trk_cand = '{valid:1'b1, is_load:1'b1, slot:2'd0, addr:11'h021, reg_idx:2'd3};
    #1 check("trk_load_other_addr", trk_stall, 0);
    trk_cand = '{valid:1'b1, is_load:1'b1, slot:2'd1, addr:11'h020, reg_idx:2'd3};
    #1 check("trk_load_other_slot", trk_stall, 0);
    trk_cand = '{valid:1'b1, is_load:1'b0, slot:2'd0, addr:11'h020, reg_idx:2'd0};
    #1 check("trk_store_after_store", trk_stall, 0);
    trk_cand = '{valid:1'b1, is_load:1'b1, slot:2'd0, addr:11'h020, reg_idx:2'd3};
    @(negedge clk);
    #1 check("trk_load_after_store_h1", trk_stall, 1);
    @(negedge clk);
    #1 check("trk_load_store_aged_out", trk_stall, 0);
    trk_in = '{valid:1'b1, is_load:1'b1, slot:2'd1, addr:11'h005, reg_idx:2'd1};
    @(negedge clk);
    trk_in = '0;
    trk_cand = '{valid:1'b1, is_load:1'b0, slot:2'd3, addr:11'h300, reg_idx:2'd1};
    #1 check("trk_store_after_load_same_reg", trk_stall, 1);
    trk_cand = '{valid:1'b1, is_load:1'b0, slot:2'd3, addr:11'h300, reg_idx:2'd2};
    #1 check("trk_store_after_load_other_reg", trk_stall, 0);
    trk_cand = '{valid:1'b0, is_load:1'b0, slot:2'd3, addr:11'h300, reg_idx:2'd1};
    #1 check("trk_invalid_cand", trk_stall, 0);

    @(negedge clk);
    check("final_beats_left", exp_q.size(), 0);
    check("final_done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
